// File: rtl/mips_pkg.sv
// Shared constants and the write-back queue entry type for the MIPS register datapath.
package mips_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Circular FIFO of pending register writes.
// Two search ports return the youngest queued entry matching an address.
module wb_queue
    import mips_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           push_i,
    input  wb_entry_t                      entry_i,
    input  logic                           pop_i,
    output wb_entry_t                      head_o,
    output logic [$clog2(Depth+1)-1:0]     count_o,
    output logic                           full_o,
    output logic                           empty_o,
    input  logic [ADDR_W-1:0]              srch_a_i,
    output logic                           hit_a_o,
    output logic [DATA_W-1:0]              data_a_o,
    input  logic [ADDR_W-1:0]              srch_b_i,
    output logic                           hit_b_o,
    output logic [DATA_W-1:0]              data_b_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    wb_entry_t         mem_q [Depth];
    logic [PtrW-1:0]   head_q, tail_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   idx;

    // Occupancy next state: +1 push only, -1 pop only, else unchanged.
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers; pointers wrap naturally since Depth is a power of 2.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + 1'b1;
            if (pop_i)  head_q <= head_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[tail_q] <= entry_i;
    end

    // Walk entries oldest to youngest from head so later matches override earlier ones.
    always_comb begin
        hit_a_o  = 1'b0;
        data_a_o = '0;
        hit_b_o  = 1'b0;
        data_b_o = '0;
        idx      = '0;
        for (int i = 0; i < Depth; i++) begin
            idx = head_q + PtrW'(i);
            if (CntW'(i) < count_q) begin
                if (mem_q[idx].addr == srch_a_i) begin
                    hit_a_o  = 1'b1;
                    data_a_o = mem_q[idx].data;
                end
                if (mem_q[idx].addr == srch_b_i) begin
                    hit_b_o  = 1'b1;
                    data_b_o = mem_q[idx].data;
                end
            end
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/wb_regfile.sv
// 32 x 32-bit MIPS register file with a buffered write-back port.
// Accepted writes are queued, committed one per cycle, and forwarded to reads while pending.
module wb_regfile #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          commit_en,
    input  logic [ADDR_W-1:0]             rd_addr_a,
    output logic [DATA_W-1:0]             rd_data_a,
    input  logic [ADDR_W-1:0]             rd_addr_b,
    output logic [DATA_W-1:0]             rd_data_b,
    output logic [$clog2(DEPTH+1)-1:0]    pending,
    output logic                          empty,
    output logic                          full
);

    import mips_pkg::*;

    logic               accept, push, pop;
    wb_entry_t          wr_entry, head_entry;
    logic               hit_a, hit_b;
    logic [DATA_W-1:0]  fwd_a, fwd_b;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];

    assign wr_ready = !full;
    assign accept   = wr_valid && wr_ready && !reset;
    // Writes to r0 complete the handshake but are dropped here.
    assign push     = accept && (wr_addr != REG_ZERO);
    assign pop      = commit_en && !empty && !reset;

    assign wr_entry.addr = wr_addr;
    assign wr_entry.data = wr_data;

    wb_queue #(
        .Depth (DEPTH)
    ) u_queue (
        .clk_i    (clk),
        .reset_i  (reset),
        .push_i   (push),
        .entry_i  (wr_entry),
        .pop_i    (pop),
        .head_o   (head_entry),
        .count_o  (pending),
        .full_o   (full),
        .empty_o  (empty),
        .srch_a_i (rd_addr_a),
        .hit_a_o  (hit_a),
        .data_a_o (fwd_a),
        .srch_b_i (rd_addr_b),
        .hit_b_o  (hit_b),
        .data_b_o (fwd_b)
    );

    // Register array: cleared on reset, written from the queue head on commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (pop && (head_entry.addr != REG_ZERO)) begin
            regs_q[head_entry.addr] <= head_entry.data;
        end
    end

    // Read muxes: r0 is hardwired zero, then youngest pending write, then the array.
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        rd_data_b = regs_q[rd_addr_b];
        if (rd_addr_a == REG_ZERO) begin
            rd_data_a = '0;
        end else if (hit_a) begin
            rd_data_a = fwd_a;
        end
        if (rd_addr_b == REG_ZERO) begin
            rd_data_b = '0;
        end else if (hit_b) begin
            rd_data_b = fwd_b;
        end
    end

endmodule
